uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
UART transmit serializer sitting directly downstream of the system controller's TX path. It accepts one parallel byte via p_data/data_valid, then drives a framed serial bit stream on tx_out, one bit per clk cycle. The frame is start, data LSB-first, optional parity, then stop. busy back-pressures the controller, which only presents a new byte while busy is low. clk is the baud-rate clock from the clock divider.

Parameters:
DATA_WIDTH, 8, width of parallel data and number of data bits per frame (>=2).

Ports:
clk  input  1  baud-rate clock, all flops on rising edge
reset  input  1  asynchronous, active-low reset
p_data  input  DATA_WIDTH  byte to transmit; sampled only on acceptance
data_valid  input  1  request to transmit p_data
par_en  input  1  1 = insert parity bit; sampled on acceptance
par_typ  input  1  0 = even, 1 = odd parity; sampled on acceptance
tx_out  output  1  serial line; idle high
busy  output  1  high while a frame is being transmitted

Behaviour:
- Reset (reset low, async): state=IDLE, tx_out=1, busy=0, shift register=0, bit counter=0, latched par_en/par_typ=0. This takes effect immediately, mid-frame included. There is no resumption; the line returns high.
- All outputs are registered. There is no combinational path from inputs to outputs.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_out=1, busy=0.
  - If data_valid=1 at a rising edge: latch p_data, par_en and par_typ; compute the parity bit from latched data; go to START.
  - On that same edge, tx_out<=0 and busy<=1, so acceptance-to-start-bit latency is 0 cycles after the sampling edge.
- START:
  - Lasts 1 cycle with tx_out=0, then go to DATA with counter=0.
  - tx_out<=data[0] on that transition edge.
- DATA:
  - Lasts DATA_WIDTH cycles; tx_out=data[counter], LSB first.
  - Counter increments each cycle.
  - On counter==DATA_WIDTH-1: go to PARITY if latched par_en=1, else go to STOP.
- PARITY:
  - Lasts 1 cycle.
  - tx_out = XOR of latched data for even parity, XNOR for odd parity.
  - Then go to STOP.
- STOP:
  - Lasts 1 cycle with tx_out=1, busy=1.
  - Then go to IDLE unconditionally, with busy<=0.
- Frame length: busy is high for 1+DATA_WIDTH+par_en+1 cycles (10 or 11 with default width).
- data_valid while busy=1 is ignored, with no queuing. Changes to p_data, par_en or par_typ during a frame do not affect that frame.
- Back-to-back: if data_valid is held high, the next frame is accepted on the first edge in IDLE. There is exactly 1 idle-high cycle between the stop bit and the next start bit.
- Counter width is clog2(DATA_WIDTH). The counter saturates or resets to 0 outside DATA, so it never wraps into an illegal index.
- Illegal FSM encoding recovers to IDLE with tx_out=1, busy=0.

Test Plan:
- Reset release, data_valid=0 for 20 cycles -> tx_out=1 and busy=0 every cycle.
- p_data=0xA5, par_en=0, 1-cycle data_valid -> tx_out sequence 0,1,0,1,0,0,1,0,1,1 (start, data LSB-first, stop); busy high for exactly 10 cycles, then 0.
- p_data=0xA5, par_en=1, par_typ=0 -> parity bit 0 after the data bits, busy high for 11 cycles. Repeat with par_typ=1 -> parity bit 1. Repeat with p_data=0x07, par_typ=0 -> parity 1.
- Accept 0x3C; pulse data_valid with p_data=0xFF during the DATA state -> the frame still carries 0x3C, 0xFF is never sent, and busy falls after 10 cycles.
- data_valid held high with p_data=0x55 then 0xAA (par_en=0) -> two frames; exactly one idle-high cycle between the stop bit and the next start bit; second frame data is 0xAA.
- Assert reset low during the 4th data bit -> tx_out=1 and busy=0 asynchronously, before the next clk edge. After release, an IDLE accept of 0x81 produces a clean full frame.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmit serializer: start bit, DATA_WIDTH data bits LSB first,
// optional parity bit, stop bit. One bit per clk (baud) cycle.
// tx_out and busy are registered; they are loaded from the next-state
// decode so each bit appears on the edge that enters its state.
//
// state  | meaning
// -------+---------------------------------------------
// IDLE   | line high, waiting for data_valid
// START  | driving the start bit (0)
// DATA   | driving data bits, LSB first
// PARITY | driving the parity bit (only when par_en latched)
// STOP   | driving the stop bit (1), busy still high
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  tx_nxt;
  logic                  busy_nxt;
  logic                  accept;

  assign accept = (state == S_IDLE) && data_valid;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; any unused encoding falls back to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (data_valid) state_nxt = S_START;
      S_START:  state_nxt = S_DATA;
      S_DATA:   if (cnt_q == CNT_LAST) state_nxt = par_en_q ? S_PARITY : S_STOP;
      S_PARITY: state_nxt = S_STOP;
      S_STOP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output decode: value the line must carry once the next state is entered
  always_comb begin
    tx_nxt   = 1'b1;
    busy_nxt = 1'b1;
    case (state_nxt)
      S_IDLE:   busy_nxt = 1'b0;
      S_START:  tx_nxt   = 1'b0;
      S_DATA:   tx_nxt   = shift_q[0];
      S_PARITY: tx_nxt   = par_bit_q;
      S_STOP:   tx_nxt   = 1'b1;
      default: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
      end
    endcase
  end

  // Output registers, frame latches, shift register and bit counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_out    <= 1'b1;
      busy      <= 1'b0;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      tx_out <= tx_nxt;
      busy   <= busy_nxt;
      if (accept) begin
        shift_q   <= p_data;
        par_en_q  <= par_en;
        // even parity = XOR of data, odd parity = XNOR
        par_bit_q <= (^p_data) ^ par_typ;
      end else if (state_nxt == S_DATA) begin
        // tx_nxt already took bit 0, so expose the next bit
        shift_q <= shift_q >> 1;
      end
      // counter only runs inside DATA and is parked at 0 elsewhere
      if (state == S_DATA && state_nxt == S_DATA) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: a frame-level reference model (queue of expected
// line/busy values per cycle) checked every cycle, plus directed frames
// compared against hand-written bit sequences.
module tb_uart_tx_frame;

  logic       clk;
  logic       reset;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic       tx_out;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // each entry is {busy, tx} for one baud cycle
  logic [1:0] exp_q[$];
  logic [1:0] cur;

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // A whole frame plus the one mandatory idle cycle before the next accept
  task automatic build_frame(input logic [7:0] d, input logic pe, input logic pt);
    int ones;
    exp_q.push_back(2'b10);
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, d[i]});
    if (pe) begin
      ones = $countones(d);
      exp_q.push_back({1'b1, pt ? ((ones % 2) == 0) : ((ones % 2) == 1)});
    end
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b01);
  endtask

  // One clock: update the model at the rising edge, check at the falling edge
  task automatic cycle();
    @(posedge clk);
    if (!reset) begin
      exp_q.delete();
      cur = 2'b01;
    end else begin
      if (exp_q.size() == 0 && data_valid) build_frame(p_data, par_en, par_typ);
      if (exp_q.size() != 0) cur = exp_q.pop_front();
      else cur = 2'b01;
    end
    @(negedge clk);
    check("tx", {31'd0, tx_out}, {31'd0, cur[0]});
    check("busy", {31'd0, busy}, {31'd0, cur[1]});
  endtask

  // Single-pulse frame; collects the serial bits while busy and compares
  // length and content against hand-derived constants.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input bit glitch, input int exp_len,
                            input logic [31:0] exp_seq, input string tag);
    int          n;
    logic [31:0] seq;
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    data_valid = 1'b1;
    cycle();
    data_valid = 1'b0;
    n   = busy ? 1 : 0;
    seq = {31'd0, tx_out};
    for (int i = 0; i < 20; i++) begin
      if (glitch && i == 3) begin
        data_valid = 1'b1;
        p_data     = 8'hFF;
        par_en     = 1'b1;
        par_typ    = 1'b1;
      end
      if (glitch && i == 4) data_valid = 1'b0;
      cycle();
      if (!busy) break;
      n++;
      seq = (seq << 1) | {31'd0, tx_out};
    end
    check({tag, "_len"}, n, exp_len);
    check({tag, "_bits"}, seq, exp_seq);
    repeat (2) cycle();
  endtask

  initial begin
    reset      = 1'b0;
    p_data     = 8'h00;
    data_valid = 1'b0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    cur        = 2'b01;

    repeat (3) cycle();
    reset = 1'b1;
    repeat (20) cycle();

    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 10, 32'b0101001011,  "a5_nopar");
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 11, 32'b01010010101, "a5_even");
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 11, 32'b01010010111, "a5_odd");
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 11, 32'b01110000011, "07_even");
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 10, 32'b0001111001,  "3c_ignore");

    // back-to-back with data_valid held; the model demands one idle cycle
    par_en     = 1'b0;
    par_typ    = 1'b0;
    p_data     = 8'h55;
    data_valid = 1'b1;
    cycle();
    p_data = 8'hAA;
    repeat (11) cycle();
    data_valid = 1'b0;
    repeat (12) cycle();

    // randomized traffic, inputs changing freely mid-frame
    for (int i = 0; i < 400; i++) begin
      data_valid = ($urandom % 4) != 0;
      p_data     = 8'($urandom);
      par_en     = 1'($urandom);
      par_typ    = 1'($urandom);
      cycle();
    end
    data_valid = 1'b0;
    repeat (13) cycle();

    // reset during the 4th data bit (0xF0 bit 3 = 0, so the line is low)
    p_data     = 8'hF0;
    par_en     = 1'b1;
    par_typ    = 1'b0;
    data_valid = 1'b1;
    cycle();
    data_valid = 1'b0;
    repeat (4) cycle();
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("rst_async_tx", {31'd0, tx_out}, 32'd1);
    check("rst_async_busy", {31'd0, busy}, 32'd0);
    repeat (2) cycle();
    reset = 1'b1;
    repeat (2) cycle();
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 10, 32'b0100000011, "81_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
